// File: rtl/bcd_conv_sched.sv
// Two-requester round-robin front end sharing one iterative double-dabble
// binary-to-BCD engine; result registered, tagged with owner id, held until next.
module bcd_conv_sched #(
  parameter int unsigned BIN_W  = 18,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [BIN_W-1:0]      bin0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [BIN_W-1:0]      bin1,
  output logic                  ack1,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_id,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cur_id_q, cur_id_d;
  logic               last_id_q, last_id_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               out_id_q, out_id_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               any_req_c;
  logic               winner_c;
  logic [BIN_W-1:0]   win_bin_c;
  logic [BCD_W-1:0]   dig_corr_c;
  logic [BCD_W-1:0]   dig_shift_c;
  logic [BIN_W-1:0]   bin_shift_c;
  logic               last_shift_c;

  // Arbitration: a lone requester wins; on contention the one not served last.
  always_comb begin
    any_req_c    = req0 | req1;
    winner_c     = (req0 & req1) ? ~last_id_q : req1;
    win_bin_c    = winner_c ? bin1 : bin0;
    last_shift_c = (cnt_q == LAST_CNT);
  end

  // One double-dabble step: parallel +3 on pre-shift digits, then a single chain shift.
  always_comb begin
    dig_corr_c = dig_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (dig_q[4*k +: 4] >= 4'd5) begin
        dig_corr_c[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
      end
    end
    dig_shift_c = {dig_corr_c[BCD_W-2:0], bin_sr_q[BIN_W-1]};
    bin_shift_c = {bin_sr_q[BIN_W-2:0], 1'b0};
  end

  // State register and all datapath/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_sr_q    <= '0;
      dig_q       <= '0;
      cnt_q       <= '0;
      cur_id_q    <= 1'b0;
      last_id_q   <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      bcd_q       <= '0;
      out_id_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_sr_q    <= bin_sr_d;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      cur_id_q    <= cur_id_d;
      last_id_q   <= last_id_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      bcd_q       <= bcd_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req_c)    state_d = SHIFT;
      SHIFT:   if (last_shift_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    bin_sr_d    = bin_sr_q;
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    cur_id_d    = cur_id_q;
    last_id_d   = last_id_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    bcd_d       = bcd_q;
    out_id_d    = out_id_q;
    out_valid_d = 1'b0;
    busy_d      = (state_d == SHIFT);
    unique case (state_q)
      IDLE: begin
        if (any_req_c) begin
          bin_sr_d  = win_bin_c;
          dig_d     = '0;
          cnt_d     = '0;
          cur_id_d  = winner_c;
          last_id_d = winner_c;
          ack0_d    = ~winner_c;
          ack1_d    = winner_c;
        end
      end
      SHIFT: begin
        bin_sr_d = bin_shift_c;
        dig_d    = dig_shift_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_shift_c) begin
          bcd_d       = dig_shift_c;
          out_id_d    = cur_id_q;
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign bcd_out   = bcd_q;
  assign out_id    = out_id_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed self-checking bench for bcd_conv_sched: latency, conversion values,
// arbitration order, back-to-back spacing and mid-conversion reset.
module tb_bcd_conv_sched;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [17:0] bin0, bin1;
  logic        ack0, ack1;
  logic [23:0] bcd_out;
  logic        out_id;
  logic        out_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int both_ack_cnt = 0;
  int ack0_cnt = 0;
  int valid_cnt = 0;

  bcd_conv_sched #(.BIN_W(18), .DIGITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .bin0(bin0), .ack0(ack0),
    .req1(req1), .bin1(bin1), .ack1(ack1),
    .bcd_out(bcd_out), .out_id(out_id), .out_valid(out_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ack0 && ack1) both_ack_cnt++;
    if (ack0) ack0_cnt++;
    if (out_valid) valid_cnt++;
  end

  // Drives one request from a negedge and reports what came back; no checking here.
  task automatic run_conv(input bit id, input logic [17:0] bin,
                          output int ack_lat, output logic a0, output logic a1,
                          output logic bsy, output int val_lat,
                          output logic [23:0] bcd, output logic oid);
    ack_lat = 0;
    val_lat = 0;
    if (id) begin req1 = 1'b1; bin1 = bin; end
    else    begin req0 = 1'b1; bin0 = bin; end
    do begin
      @(negedge clk);
      ack_lat++;
    end while (!(ack0 || ack1) && ack_lat < 40);
    a0  = ack0;
    a1  = ack1;
    bsy = busy;
    req0 = 1'b0;
    req1 = 1'b0;
    bin0 = 18'h155AA;
    bin1 = 18'h2AA55;
    do begin
      @(negedge clk);
      val_lat++;
    end while (!out_valid && val_lat < 40);
    bcd = bcd_out;
    oid = out_id;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, ack1, out_valid, busy, out_id, bcd_out} !== 29'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ack0=%b ack1=%b v=%b busy=%b id=%b bcd=%h, want all 0",
               ack0, ack1, out_valid, busy, out_id, bcd_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int al, vl; logic a0, a1, b, oid; logic [23:0] bcd;
    run_conv(1'b0, 18'd0, al, a0, a1, b, vl, bcd, oid);
    checks++;
    if (al !== 1 || a0 !== 1'b1 || a1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_ack: lat=%0d ack0=%b ack1=%b, want lat=1 ack0=1 ack1=0", al, a0, a1);
    end
    checks++;
    if (b !== 1'b1) begin
      errors++; $display("FAIL zero_busy: busy=%b during shift, want 1", b);
    end
    checks++;
    if (vl !== 18) begin
      errors++; $display("FAIL zero_latency: ack->valid %0d cycles, want 18", vl);
    end
    checks++;
    if (bcd !== 24'h000000 || oid !== 1'b0) begin
      errors++; $display("FAIL zero_result: bcd=%h id=%b, want 000000 id 0", bcd, oid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || bcd_out !== 24'h000000) begin
      errors++; $display("FAIL zero_hold: valid=%b bcd=%h, want 0 and 000000", out_valid, bcd_out);
    end
  endtask

  task automatic test_max();
    int al, vl; logic a0, a1, b, oid; logic [23:0] bcd;
    run_conv(1'b0, 18'd262143, al, a0, a1, b, vl, bcd, oid);
    checks++;
    if (bcd !== 24'h262143 || oid !== 1'b0 || vl !== 18) begin
      errors++;
      $display("FAIL max_result: bcd=%h id=%b lat=%0d, want 262143 id 0 lat 18", bcd, oid, vl);
    end
  endtask

  task automatic test_req1_alone();
    int al, vl, a0_before; logic a0, a1, b, oid; logic [23:0] bcd;
    a0_before = ack0_cnt;
    run_conv(1'b1, 18'd12345, al, a0, a1, b, vl, bcd, oid);
    checks++;
    if (al !== 1 || a1 !== 1'b1 || a0 !== 1'b0) begin
      errors++; $display("FAIL req1_ack: lat=%0d ack0=%b ack1=%b, want 1/0/1", al, a0, a1);
    end
    checks++;
    if (bcd !== 24'h012345 || oid !== 1'b1) begin
      errors++; $display("FAIL req1_result: bcd=%h id=%b, want 012345 id 1", bcd, oid);
    end
    checks++;
    if (ack0_cnt !== a0_before) begin
      errors++; $display("FAIL req1_no_ack0: ack0 pulsed %0d times, want 0", ack0_cnt - a0_before);
    end
  endtask

  task automatic test_simultaneous();
    int gap;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req0 = 1'b1; bin0 = 18'd999;
    req1 = 1'b1; bin1 = 18'd100000;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      errors++; $display("FAIL simul_first_ack: ack0=%b ack1=%b, want 1 0", ack0, ack1);
    end
    req0 = 1'b0;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!out_valid && gap < 40);
    checks++;
    if (bcd_out !== 24'h000999 || out_id !== 1'b0 || gap !== 18) begin
      errors++;
      $display("FAIL simul_first: bcd=%h id=%b lat=%0d, want 000999 id 0 lat 18", bcd_out, out_id, gap);
    end
    gap = 0;
    do begin
      @(negedge clk); gap++;
      if (ack1) req1 = 1'b0;
    end while (!out_valid && gap < 40);
    checks++;
    if (bcd_out !== 24'h100000 || out_id !== 1'b1 || gap !== 19) begin
      errors++;
      $display("FAIL simul_second: bcd=%h id=%b gap=%0d, want 100000 id 1 gap 19", bcd_out, out_id, gap);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ids;
    int n, t, last_t, bad_gap, bad_busy;
    n = 0; t = 0; last_t = 0; bad_gap = 0; bad_busy = 0; ids = '0;
    req0 = 1'b1; bin0 = 18'd7;
    req1 = 1'b1; bin1 = 18'd65536;
    while (n < 4 && t < 200) begin
      @(negedge clk); t++;
      if (out_valid) begin
        ids[n] = out_id;
        if (t - last_t != 19) bad_gap++;
        if (busy !== 1'b0) bad_busy++;
        last_t = t;
        n++;
        if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
        @(negedge clk); t++;
        if (n < 4 && busy !== 1'b1) bad_busy++;
        if (n == 4 && busy !== 1'b0) bad_busy++;
      end
    end
    checks++;
    if (n !== 4 || ids !== 4'b1010) begin
      errors++; $display("FAIL b2b_order: %0d results ids(3..0)=%b, want 4 results 1010", n, ids);
    end
    checks++;
    if (bad_gap !== 0) begin
      errors++; $display("FAIL b2b_spacing: %0d gaps not 19 cycles, want 0", bad_gap);
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++; $display("FAIL b2b_busy: %0d busy violations, want 0", bad_busy);
    end
    checks++;
    if (bcd_out !== 24'h065536) begin
      errors++; $display("FAIL b2b_value: bcd=%h, want 065536", bcd_out);
    end
  endtask

  task automatic test_reset_mid();
    int al, vl, vc; logic a0, a1, b, oid; logic [23:0] bcd;
    req0 = 1'b1; bin0 = 18'd262143;
    @(negedge clk);
    req0 = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    vc = valid_cnt;
    #1;
    checks++;
    if ({ack0, ack1, out_valid, busy, out_id, bcd_out} !== 29'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b v=%b id=%b bcd=%h, want all 0", busy, out_valid, out_id, bcd_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checks++;
    if (valid_cnt !== vc || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_discard: %0d out_valid pulses busy=%b, want 0 and 0", valid_cnt - vc, busy);
    end
    run_conv(1'b0, 18'd42, al, a0, a1, b, vl, bcd, oid);
    checks++;
    if (bcd !== 24'h000042 || oid !== 1'b0 || a0 !== 1'b1) begin
      errors++; $display("FAIL reset_mid_after: bcd=%h id=%b ack0=%b, want 000042 id 0 ack0 1", bcd, oid, a0);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_req1_alone();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (both_ack_cnt !== 0) begin
      errors++; $display("FAIL ack_exclusive: ack0&ack1 together %0d cycles, want 0", both_ack_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
